branch_ctrl: RTL and testbench

- Execute-stage branch/jump resolution controller.
- Accepts one control-flow op per handshake and configures an internal branch_comp for signed or unsigned compare from funct3.
- Resolves taken/target, compares against the fetch prediction, and on mispredict issues a redirect followed by a fixed-length pipeline flush.
- Keeps branch and mispredict statistics counters.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/branch_ctrl_if.sv | 47 ++++
 rtl/branch_comp.sv | 25 ++
 rtl/branch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the execute-stage branch controller:
// funct3 branch encodings, controller FSM states, PC increment and
// small decode helpers.
package rv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_RESOLVE = 2'd1,
    CTRL_FLUSH   = 2'd2
  } ctrl_state_e;

  // Branch condition from comparator flags; reserved encodings never take.
  function automatic logic br_cond(input logic [2:0] f3, input logic eq, input logic lt);
    logic c;
    c = 1'b0;
    case (f3)
      F3_BEQ:           c = eq;
      F3_BNE:           c = ~eq;
      F3_BLT, F3_BLTU:  c = lt;
      F3_BGE, F3_BGEU:  c = ~lt;
      default:          c = 1'b0;
    endcase
    return c;
  endfunction

  // funct3 010/011 are not branch conditions.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Op issue / result bus between the issue stage and branch_ctrl.
// master: drives the op (in_valid, decode bits, operands, prediction, kill)
//         and observes results, redirect, flush and statistics.
// slave : the controller side.
interface branch_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   imm;
  logic              pred_taken;
  logic              kill;
  logic              out_valid;
  logic              taken;
  logic [XLEN-1:0]   link_pc;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              misalign;
  logic              illegal;
  logic              flush_out;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  mispred_count;

  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val,
           pc, imm, pred_taken, kill,
    input  in_ready, out_valid, taken, link_pc, redirect_valid, redirect_pc,
           misalign, illegal, flush_out, br_count, mispred_count
  );

  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val,
           pc, imm, pred_taken, kill,
    output in_ready, out_valid, taken, link_pc, redirect_valid, redirect_pc,
           misalign, illegal, flush_out, br_count, mispred_count
  );

endinterface

// File: rtl/branch_comp.sv
// Operand comparator for conditional branches.
// a_i, b_i  : operands
// br_un_i   : 1 = unsigned compare, 0 = signed compare
// br_eq_c_o : a == b (combinational)
// br_lt_c_o : a < b under the selected signedness (combinational)
module branch_comp #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            br_un_i,
  output logic            br_eq_c_o,
  output logic            br_lt_c_o
);

  always_comb begin
    br_eq_c_o = (a_i == b_i);
    if (br_un_i) begin
      br_lt_c_o = (a_i < b_i);
    end else begin
      br_lt_c_o = ($signed(a_i) < $signed(b_i));
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump resolution controller.
// clk, rst : clock and asynchronous active-high reset
// bus      : op handshake in, resolved result / redirect / flush / counters out
// One op is latched in IDLE, resolved in RESOLVE (result registered on the
// following edge), and a mispredict holds flush_out for FLUSH_CYCLES cycles.
module branch_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  branch_ctrl_if.slave bus
);

  localparam int unsigned FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam bit          HAS_FLUSH = (FLUSH_CYCLES > 0);

  ctrl_state_e       state_q;
  logic [FC_W-1:0]   flush_cnt_q;

  // Latched op
  logic              op_br_q, op_jal_q, op_jalr_q, pred_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, pc_q, imm_q;

  // Registered outputs
  logic              in_ready_q, out_valid_q, taken_q, redirect_valid_q;
  logic              misalign_q, illegal_q, flush_q;
  logic [XLEN-1:0]   link_pc_q, redirect_pc_q;
  logic [CNT_W-1:0]  br_cnt_q, mis_cnt_q;

  // Resolution of the latched op
  logic              br_eq, br_lt;
  logic              taken_d, mispred_d, misalign_d, illegal_d;
  logic [XLEN-1:0]   target_d, link_pc_d, redirect_pc_d;

  branch_comp #(.XLEN(XLEN)) u_comp (
    .a_i       (rs1_q),
    .b_i       (rs2_q),
    .br_un_i   (f3_q[1]),
    .br_eq_c_o (br_eq),
    .br_lt_c_o (br_lt)
  );

  // Direction, target and prediction check for the op sitting in RESOLVE.
  always_comb begin
    taken_d   = op_jal_q | op_jalr_q | (op_br_q & br_cond(f3_q, br_eq, br_lt));
    link_pc_d = pc_q + XLEN'(PC_INC);
    if (op_jalr_q) begin
      target_d = (rs1_q + imm_q) & ~XLEN'(1);
    end else begin
      target_d = pc_q + imm_q;
    end
    redirect_pc_d = taken_d ? target_d : link_pc_d;
    mispred_d     = (taken_d != pred_q);
    misalign_d    = taken_d & (target_d[1:0] != 2'b00);
    illegal_d     = op_br_q & f3_illegal(f3_q);
  end

  // Controller FSM with registered outputs; kill overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= CTRL_IDLE;
      flush_cnt_q      <= '0;
      op_br_q          <= 1'b0;
      op_jal_q         <= 1'b0;
      op_jalr_q        <= 1'b0;
      pred_q           <= 1'b0;
      f3_q             <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      pc_q             <= '0;
      imm_q            <= '0;
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
      taken_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      misalign_q       <= 1'b0;
      illegal_q        <= 1'b0;
      flush_q          <= 1'b0;
      link_pc_q        <= '0;
      redirect_pc_q    <= '0;
      br_cnt_q         <= '0;
      mis_cnt_q        <= '0;
    end else begin
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      if (bus.kill) begin
        state_q    <= CTRL_IDLE;
        in_ready_q <= 1'b1;
        flush_q    <= 1'b0;
      end else begin
        case (state_q)
          CTRL_IDLE: begin
            if (bus.in_valid) begin
              op_br_q    <= bus.is_branch;
              op_jal_q   <= bus.is_jal;
              op_jalr_q  <= bus.is_jalr;
              pred_q     <= bus.pred_taken;
              f3_q       <= bus.funct3;
              rs1_q      <= bus.rs1_val;
              rs2_q      <= bus.rs2_val;
              pc_q       <= bus.pc;
              imm_q      <= bus.imm;
              state_q    <= CTRL_RESOLVE;
              in_ready_q <= 1'b0;
            end
          end
          CTRL_RESOLVE: begin
            out_valid_q      <= 1'b1;
            taken_q          <= taken_d;
            link_pc_q        <= link_pc_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            illegal_q        <= illegal_d;
            redirect_valid_q <= mispred_d;
            br_cnt_q         <= br_cnt_q + CNT_W'(1);
            if (mispred_d) begin
              mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
            if (mispred_d && HAS_FLUSH) begin
              state_q     <= CTRL_FLUSH;
              flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
              flush_q     <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q    <= CTRL_IDLE;
              in_ready_q <= 1'b1;
            end
          end
          CTRL_FLUSH: begin
            if (flush_cnt_q == '0) begin
              state_q    <= CTRL_IDLE;
              flush_q    <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              flush_cnt_q <= flush_cnt_q - FC_W'(1);
            end
          end
          default: begin
            state_q    <= CTRL_IDLE;
            flush_q    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.taken          = taken_q;
  assign bus.link_pc        = link_pc_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misalign       = misalign_q;
  assign bus.illegal        = illegal_q;
  assign bus.flush_out      = flush_q;
  assign bus.br_count       = br_cnt_q;
  assign bus.mispred_count  = mis_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: behavioural op-level model plus
// hand-computed pins. A second instance with 4-bit counters shares the
// stimulus so counter wrap is reached in a short run.
module tb_branch_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_ctrl_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  branch_ctrl_if #(.XLEN(XLEN), .CNT_W(4))  bus_s ();

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  assign bus_s.in_valid   = bus.in_valid;
  assign bus_s.is_branch  = bus.is_branch;
  assign bus_s.is_jal     = bus.is_jal;
  assign bus_s.is_jalr    = bus.is_jalr;
  assign bus_s.funct3     = bus.funct3;
  assign bus_s.rs1_val    = bus.rs1_val;
  assign bus_s.rs2_val    = bus.rs2_val;
  assign bus_s.pc         = bus.pc;
  assign bus_s.imm        = bus.imm;
  assign bus_s.pred_taken = bus.pred_taken;
  assign bus_s.kill       = bus.kill;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend;
  int          m_flush_left;
  logic        m_br, m_jal, m_jalr, m_pred;
  logic [2:0]  m_f3;
  logic [31:0] m_rs1, m_rs2, m_pc, m_imm;

  logic        e_rdy, e_ov, e_rv, e_taken, e_misal, e_ill, e_flush;
  logic [31:0] e_link, e_rpc;
  int          e_br, e_mis;

  always @(posedge clk or posedge rst) begin : model
    logic        cond, ill, tk, mis;
    logic [31:0] tgt;
    e_ov = 1'b0;
    e_rv = 1'b0;
    if (rst) begin
      m_pend = 1'b0; m_flush_left = 0;
      e_taken = 1'b0; e_misal = 1'b0; e_ill = 1'b0;
      e_link = '0; e_rpc = '0; e_br = 0; e_mis = 0;
    end else if (bus.kill) begin
      m_pend = 1'b0;
      m_flush_left = 0;
    end else if (m_pend) begin
      cond = 1'b0;
      ill  = 1'b0;
      case (m_f3)
        3'b000:  cond = (m_rs1 == m_rs2);
        3'b001:  cond = (m_rs1 != m_rs2);
        3'b100:  cond = ($signed(m_rs1) < $signed(m_rs2));
        3'b101:  cond = !($signed(m_rs1) < $signed(m_rs2));
        3'b110:  cond = (m_rs1 < m_rs2);
        3'b111:  cond = !(m_rs1 < m_rs2);
        default: ill = 1'b1;
      endcase
      tk  = m_jal | m_jalr | (m_br & cond);
      tgt = m_jalr ? ((m_rs1 + m_imm) & 32'hFFFF_FFFE) : (m_pc + m_imm);
      mis = (tk != m_pred);
      e_ov    = 1'b1;
      e_rv    = mis;
      e_taken = tk;
      e_link  = m_pc + 32'd4;
      e_rpc   = tk ? tgt : (m_pc + 32'd4);
      e_misal = tk && (tgt[1:0] != 2'b00);
      e_ill   = ill & m_br;
      e_br    = e_br + 1;
      if (mis) e_mis = e_mis + 1;
      m_flush_left = mis ? FLUSH : 0;
      m_pend = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (bus.in_valid) begin
      m_pend = 1'b1;
      m_br = bus.is_branch; m_jal = bus.is_jal; m_jalr = bus.is_jalr;
      m_f3 = bus.funct3; m_rs1 = bus.rs1_val; m_rs2 = bus.rs2_val;
      m_pc = bus.pc; m_imm = bus.imm; m_pred = bus.pred_taken;
    end
    e_flush = (m_flush_left > 0);
    e_rdy   = !m_pend && (m_flush_left == 0);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",      64'(bus.in_ready),       64'(e_rdy));
      chk("out_valid",     64'(bus.out_valid),      64'(e_ov));
      chk("redirect_valid",64'(bus.redirect_valid), 64'(e_rv));
      chk("flush_out",     64'(bus.flush_out),      64'(e_flush));
      chk("taken",         64'(bus.taken),          64'(e_taken));
      chk("link_pc",       64'(bus.link_pc),        64'(e_link));
      chk("redirect_pc",   64'(bus.redirect_pc),    64'(e_rpc));
      chk("misalign",      64'(bus.misalign),       64'(e_misal));
      chk("illegal",       64'(bus.illegal),        64'(e_ill));
      chk("br_count",      64'(bus.br_count),       64'(e_br % 65536));
      chk("mispred_count", 64'(bus.mispred_count),  64'(e_mis % 65536));
      chk("br_count_w4",   64'(bus_s.br_count),     64'(e_br % 16));
      chk("mispred_w4",    64'(bus_s.mispred_count),64'(e_mis % 16));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    bit acc;
    acc = 1'b0;
    bus.is_branch = br; bus.is_jal = jal; bus.is_jalr = jalr;
    bus.funct3 = f3; bus.rs1_val = rs1; bus.rs2_val = rs2;
    bus.pc = pc; bus.imm = imm; bus.pred_taken = pred;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      acc = bus.in_ready && !bus.kill;
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  logic [2:0] f3tab [6];

  initial begin
    f3tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    bus.in_valid = 1'b0; bus.is_branch = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.pc = '0; bus.imm = '0;
    bus.pred_taken = 1'b0; bus.kill = 1'b0;

    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_br_count", 64'(bus.br_count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

    // BLT signed: -1 < 1, predicted not-taken -> redirect + 2-cycle flush
    issue(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0);
    step();
    chk("blt_taken", 64'(bus.taken), 64'd1);
    chk("blt_rv", 64'(bus.redirect_valid), 64'd1);
    chk("blt_rpc", 64'(bus.redirect_pc), 64'h120);
    chk("blt_mispred_count", 64'(bus.mispred_count), 64'd1);
    chk("blt_flush1", 64'(bus.flush_out), 64'd1);
    chk("blt_rdy1", 64'(bus.in_ready), 64'd0);
    step();
    chk("blt_flush2", 64'(bus.flush_out), 64'd1);
    chk("blt_rv_pulse", 64'(bus.redirect_valid), 64'd0);
    step();
    chk("blt_flush_end", 64'(bus.flush_out), 64'd0);
    chk("blt_rdy_back", 64'(bus.in_ready), 64'd1);

    // BLTU same operands: 0xFFFFFFFF < 1 false, correctly predicted
    issue(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h104, 32'h20, 0);
    step();
    chk("bltu_taken", 64'(bus.taken), 64'd0);
    chk("bltu_rv", 64'(bus.redirect_valid), 64'd0);
    chk("bltu_rdy", 64'(bus.in_ready), 64'd1);
    chk("bltu_br_count", 64'(bus.br_count), 64'd2);

    // JALR to 0x1003 -> 0x1002, misaligned, prediction correct
    issue(0, 0, 1, 3'b000, 32'h1003, 32'd0, 32'h200, 32'd0, 1);
    step();
    chk("jalr_taken", 64'(bus.taken), 64'd1);
    chk("jalr_misalign", 64'(bus.misalign), 64'd1);
    chk("jalr_rv", 64'(bus.redirect_valid), 64'd0);
    chk("jalr_rpc", 64'(bus.redirect_pc), 64'h1002);
    chk("jalr_link", 64'(bus.link_pc), 64'h204);

    // Reserved funct3 010 with predicted taken
    issue(1, 0, 0, 3'b010, 32'd5, 32'd5, 32'h300, 32'h40, 1);
    step();
    chk("ill_illegal", 64'(bus.illegal), 64'd1);
    chk("ill_taken", 64'(bus.taken), 64'd0);
    chk("ill_rpc", 64'(bus.redirect_pc), 64'h304);
    repeat (2) step();

    // BEQ mispredict, kill in first flush cycle
    issue(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h500, 32'h10, 0);
    step();
    chk("kf_flush_on", 64'(bus.flush_out), 64'd1);
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    chk("kf_flush_off", 64'(bus.flush_out), 64'd0);
    chk("kf_rdy", 64'(bus.in_ready), 64'd1);

    // Kill while resolving: op discarded
    issue(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h600, 32'h10, 0);
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    chk("kr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("kr_rv", 64'(bus.redirect_valid), 64'd0);
    chk("kr_br_count", 64'(bus.br_count), 64'd5);
    chk("kr_mispred_count", 64'(bus.mispred_count), 64'd3);

    // Kill concurrent with offer: not accepted
    bus.is_branch = 1'b1; bus.funct3 = 3'b000; bus.rs1_val = 32'd1; bus.rs2_val = 32'd1;
    bus.pc = 32'h680; bus.imm = 32'h8; bus.pred_taken = 1'b0;
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    step();
    chk("kc_out_valid", 64'(bus.out_valid), 64'd0);
    chk("kc_br_count", 64'(bus.br_count), 64'd5);

    // JAL backwards, correct prediction; JAL wrapping past 2^32
    issue(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h400, 32'hFFFF_FFF8, 1);
    step();
    chk("jal_rpc", 64'(bus.redirect_pc), 64'h3F8);
    chk("jal_link", 64'(bus.link_pc), 64'h404);
    issue(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 0);
    step();
    chk("jalw_link", 64'(bus.link_pc), 64'd0);
    chk("jalw_rpc", 64'(bus.redirect_pc), 64'd4);
    chk("jalw_rv", 64'(bus.redirect_valid), 64'd1);

    // Back-to-back mixed branches; pushes the 4-bit counters past wrap
    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 0, f3tab[i % 6], 32'(i * 3 - 8), 32'(5 - i),
            32'h800 + 32'(i * 8), 32'(i * 2 - 6), ((i % 2) == 1));
    end
    repeat (5) step();
    chk("loop_br_count", 64'(bus.br_count), 64'd23);
    chk("loop_br_count_w4", 64'(bus_s.br_count), 64'd7);

    // Reset in the middle of RESOLVE
    issue(1, 0, 0, 3'b000, 32'd3, 32'd3, 32'h700, 32'h10, 0);
    #2 rst = 1'b1;
    #1;
    chk("rstm_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstm_taken", 64'(bus.taken), 64'd0);
    chk("rstm_link", 64'(bus.link_pc), 64'd0);
    chk("rstm_br_count", 64'(bus.br_count), 64'd0);
    chk("rstm_rdy", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;

    // Resume after reset: BGE 2 >= -3 taken, predicted taken
    issue(1, 0, 0, 3'b101, 32'd2, 32'hFFFF_FFFD, 32'h900, 32'h40, 1);
    step();
    chk("post_rst_rpc", 64'(bus.redirect_pc), 64'h940);
    chk("post_rst_br_count", 64'(bus.br_count), 64'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
